// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_pkg
//  Description : Shared key codes, code-to-digit table and debounce state
//                encodings for the 4x4 matrix keypad entry block.
//  Revision    : 1.0  initial release
// ============================================================================
package keypad_pkg;

   // Key codes are row*4 + col on the Pmod KYPD layout
   localparam logic [3:0] KEY_A     = 4'd3;
   localparam logic [3:0] KEY_B     = 4'd7;
   localparam logic [3:0] KEY_CLEAR = 4'd11;
   localparam logic [3:0] KEY_BKSP  = 4'd13;
   localparam logic [3:0] KEY_ENTER = 4'd14;
   localparam logic [3:0] KEY_D     = 4'd15;

   localparam logic [3:0] NOT_DIGIT = 4'hF;

   // Entry [code] holds the decimal value of that key, or NOT_DIGIT.
   // Codes 15..0: D E F 0 | C 9 8 7 | B 6 5 4 | A 3 2 1
   localparam logic [15:0][3:0] KEY_DIGIT = 64'hFFF0_F987_F654_F321;

   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_CONFIRM      = 2'd1,
      ST_ACCEPT       = 2'd2,
      ST_WAIT_RELEASE = 2'd3
   } deb_state_e;

   function automatic logic [3:0] key_to_digit(input logic [3:0] code);
      return KEY_DIGIT[code];
   endfunction

endpackage
`default_nettype wire

// File: rtl/bcd2bin.sv
`default_nettype none
// ============================================================================
//  Module      : bcd2bin
//  Description : Combinational 4-digit BCD to 14-bit binary converter
//                (inverse of the display path's bin2bcd).
//  Revision    : 1.0  initial release
// ============================================================================
module bcd2bin (
   input  logic [15:0] bcd,
   output logic [13:0] bin
);

   // Weighted sum of the four decades; the maximum 9999 fits in 14 bits
   always_comb begin
      bin = {10'd0, bcd[15:12]} * 14'd1000
          + {10'd0, bcd[11:8]}  * 14'd100
          + {10'd0, bcd[7:4]}   * 14'd10
          + {10'd0, bcd[3:0]};
   end

endmodule
`default_nettype wire

// File: rtl/keypad_entry.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_entry
//  Description : Scans a 4x4 matrix keypad, debounces presses per full sweep
//                and assembles up to 4 decimal digits; Enter commits the
//                entry as a binary value with a one-cycle valid pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module keypad_entry
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 100000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic        clock_100,
   input  logic        reset,
   input  logic [3:0]  row,
   output logic [3:0]  col,
   output logic [13:0] num,
   output logic        num_valid,
   output logic [15:0] digits,
   output logic [2:0]  digit_count
);

   localparam int DWELL_W = $clog2(SCAN_DIV);
   localparam int CNT_W   = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0]   CNT_TARGET = CNT_W'(DEBOUNCE_SCANS);

   logic [3:0]         row_s1_q, row_s2_q;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [1:0]         col_idx_q, col_idx_d;
   logic [3:0]         col_q, col_d;
   logic [1:0]         hits_q, hits_d;     // keys seen so far this sweep, saturating at 2
   logic [3:0]         code_q, code_d;
   deb_state_e         state_q, state_d;
   logic [3:0]         cand_q, cand_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [15:0]        digits_q, digits_d;
   logic [2:0]         count_q, count_d;
   logic [13:0]        num_q, num_d;
   logic               num_valid_q, num_valid_d;

   logic               sample, sweep_done, key_event;
   logic [3:0]         pressed;
   logic [2:0]         col_ones, sum;
   logic [1:0]         col_hits, total, row_idx;
   logic [3:0]         sweep_code, key_digit;
   logic [CNT_W-1:0]   cnt_inc;
   logic [13:0]        entry_bin;

   bcd2bin u_bcd2bin (
      .bcd (digits_q),
      .bin (entry_bin)
   );

   // Column dwell timing and per-sweep accumulation of pressed keys
   always_comb begin
      sample   = (dwell_q == DWELL_LAST);
      pressed  = ~row_s2_q;
      col_ones = 3'($countones(pressed));
      col_hits = (col_ones >= 3'd2) ? 2'd2 : col_ones[1:0];
      row_idx  = 2'd0;
      for (int r = 0; r < 4; r++) begin
         if (pressed[r]) row_idx = 2'(r);
      end
      sum        = {1'b0, hits_q} + {1'b0, col_hits};
      total      = (sum >= 3'd2) ? 2'd2 : sum[1:0];
      sweep_code = (col_hits == 2'd1) ? {row_idx, col_idx_q} : code_q;
      sweep_done = sample && (col_idx_q == 2'd3);

      dwell_d   = sample ? '0 : dwell_q + 1'b1;
      col_idx_d = sample ? col_idx_q + 2'd1 : col_idx_q;
      col_d     = sample ? {col_q[2:0], col_q[3]} : col_q;
      hits_d    = hits_q;
      code_d    = code_q;
      if (sample) begin
         hits_d = sweep_done ? 2'd0 : total;
         code_d = sweep_done ? 4'd0 : sweep_code;
      end
   end

   // Debounce next-state logic, advanced once per completed sweep
   always_comb begin
      state_d   = state_q;
      cand_d    = cand_q;
      cnt_d     = cnt_q;
      key_event = 1'b0;
      cnt_inc   = cnt_q + 1'b1;
      case (state_q)
         ST_IDLE: begin
            if (sweep_done && total == 2'd1) begin
               cand_d  = sweep_code;
               cnt_d   = CNT_W'(1);
               state_d = (DEBOUNCE_SCANS == 1) ? ST_ACCEPT : ST_CONFIRM;
            end
         end
         ST_CONFIRM: begin
            if (sweep_done) begin
               if (total != 2'd1) begin
                  state_d = ST_IDLE;
               end else if (sweep_code == cand_q) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == CNT_TARGET) state_d = ST_ACCEPT;
               end else begin
                  cand_d = sweep_code;
                  cnt_d  = CNT_W'(1);
               end
            end
         end
         ST_ACCEPT: begin
            key_event = 1'b1;
            cnt_d     = '0;
            state_d   = ST_WAIT_RELEASE;
         end
         ST_WAIT_RELEASE: begin
            if (sweep_done) begin
               if (total != 2'd0) begin
                  cnt_d = '0;
               end else if (cnt_inc == CNT_TARGET) begin
                  cnt_d   = '0;
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         default: state_d = ST_WAIT_RELEASE;
      endcase
   end

   // Digit entry editing and Enter commit on each accepted key event
   always_comb begin
      digits_d    = digits_q;
      count_d     = count_q;
      num_d       = num_q;
      num_valid_d = 1'b0;
      key_digit   = key_to_digit(cand_q);
      if (key_event) begin
         if (key_digit != NOT_DIGIT) begin
            if (count_q < 3'd4) begin
               digits_d = {digits_q[11:0], key_digit};
               count_d  = count_q + 3'd1;
            end
         end else begin
            case (cand_q)
               KEY_BKSP: begin
                  if (count_q != 3'd0) begin
                     digits_d = {4'h0, digits_q[15:4]};
                     count_d  = count_q - 3'd1;
                  end
               end
               KEY_CLEAR: begin
                  digits_d = '0;
                  count_d  = '0;
               end
               KEY_ENTER: begin
                  num_d       = entry_bin;
                  num_valid_d = 1'b1;
                  digits_d    = '0;
                  count_d     = '0;
               end
               default: ;
            endcase
         end
      end
   end

   // State registers; reset parks the debouncer in WAIT_RELEASE so a key
   // held through reset is never registered
   always_ff @(posedge clock_100) begin
      if (reset) begin
         row_s1_q    <= 4'hF;
         row_s2_q    <= 4'hF;
         dwell_q     <= '0;
         col_idx_q   <= '0;
         col_q       <= 4'b1110;
         hits_q      <= '0;
         code_q      <= '0;
         state_q     <= ST_WAIT_RELEASE;
         cand_q      <= '0;
         cnt_q       <= '0;
         digits_q    <= '0;
         count_q     <= '0;
         num_q       <= '0;
         num_valid_q <= 1'b0;
      end else begin
         row_s1_q    <= row;
         row_s2_q    <= row_s1_q;
         dwell_q     <= dwell_d;
         col_idx_q   <= col_idx_d;
         col_q       <= col_d;
         hits_q      <= hits_d;
         code_q      <= code_d;
         state_q     <= state_d;
         cand_q      <= cand_d;
         cnt_q       <= cnt_d;
         digits_q    <= digits_d;
         count_q     <= count_d;
         num_q       <= num_d;
         num_valid_q <= num_valid_d;
      end
   end

   assign col         = col_q;
   assign num         = num_q;
   assign num_valid   = num_valid_q;
   assign digits      = digits_q;
   assign digit_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_entry
//  Description : Self-checking bench for keypad_entry with a matrix keypad
//                model, a vector table, hand-written corner sequences and
//                randomized key streams against a queue-based entry model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_keypad_entry;

   localparam int SCAN_DIV       = 4;
   localparam int DEBOUNCE_SCANS = 2;
   localparam int SWEEP          = 4 * SCAN_DIV;

   logic        clock_100 = 1'b0;
   logic        reset     = 1'b1;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [13:0] num;
   logic        num_valid;
   logic [15:0] digits;
   logic [2:0]  digit_count;

   logic [15:0] held = '0;   // held[r*4+c] = key (r,c) physically pressed
   int          total = 0;
   int          bad   = 0;
   int          pulses = 0;

   typedef struct {
      int key;
      int dig;
      int cnt;
      int npulse;
      int num;
   } vec_t;

   vec_t vecs[19];

   keypad_entry #(
      .SCAN_DIV       (SCAN_DIV),
      .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
   ) dut (
      .clock_100   (clock_100),
      .reset       (reset),
      .row         (row),
      .col         (col),
      .num         (num),
      .num_valid   (num_valid),
      .digits      (digits),
      .digit_count (digit_count)
   );

   // Free-running 100 MHz-style clock
   always #5 clock_100 = ~clock_100;

   // Keypad matrix: a held key pulls its row low while its column is driven
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (held[r*4+c] && !col[c]) row[r] = 1'b0;
   end

   // Count cycles with num_valid high, sampled away from the active edge
   always @(negedge clock_100) begin
      if (num_valid) pulses++;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clock_100);
   endtask

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic press(input int code, input int sweeps);
      held[code] = 1'b1;
      tick(sweeps * SWEEP);
      held[code] = 1'b0;
      tick(4 * SWEEP);
   endtask

   // Keymap meaning of each code: decimal value, or -1 for a function key
   function automatic int digit_of(input int k);
      case (k)
         0: return 1;  1: return 2;  2: return 3;
         4: return 4;  5: return 5;  6: return 6;
         8: return 7;  9: return 8;  10: return 9;
         12: return 0;
         default: return -1;
      endcase
   endfunction

   initial begin
      int          p0;
      int          k;
      int          d;
      int          v;
      int          mnum;
      int          epulse;
      int          exp_dig;
      int          q[$];
      logic [3:0]  ecol;

      vecs = '{
         '{0,  'h0001, 1, 0, 0},    '{1,  'h0012, 2, 0, 0},
         '{2,  'h0123, 3, 0, 0},    '{4,  'h1234, 4, 0, 0},
         '{14, 0,      0, 1, 1234},
         '{10, 'h0009, 1, 0, 1234}, '{10, 'h0099, 2, 0, 1234},
         '{10, 'h0999, 3, 0, 1234}, '{10, 'h9999, 4, 0, 1234},
         '{8,  'h9999, 4, 0, 1234}, '{14, 0,      0, 1, 9999},
         '{4,  'h0004, 1, 0, 9999}, '{1,  'h0042, 2, 0, 9999},
         '{13, 'h0004, 1, 0, 9999}, '{8,  'h0047, 2, 0, 9999},
         '{14, 0,      0, 1, 47},
         '{9,  'h0008, 1, 0, 47},   '{11, 0,      0, 0, 47},
         '{14, 0,      0, 1, 0}
      };

      // Reset state
      tick(3);
      check("reset num", int'(num), 0);
      check("reset num_valid", int'(num_valid), 0);
      check("reset digits", int'(digits), 0);
      check("reset digit_count", int'(digit_count), 0);
      check("reset col", int'(col), 'b1110);

      // Column walk: each column low for SCAN_DIV cycles
      reset = 1'b0;
      for (int i = 0; i < 16; i++) begin
         ecol = 4'hF;
         ecol[(i / SCAN_DIV) % 4] = 1'b0;
         check($sformatf("col walk %0d", i), int'(col), int'(ecol));
         tick(1);
      end
      tick(2 * SWEEP);

      // Table-driven key presses, each held 3 sweeps
      for (int i = 0; i < 19; i++) begin
         p0 = pulses;
         press(vecs[i].key, 3);
         check($sformatf("vec%0d digits", i), int'(digits), vecs[i].dig);
         check($sformatf("vec%0d count", i), int'(digit_count), vecs[i].cnt);
         check($sformatf("vec%0d pulses", i), pulses - p0, vecs[i].npulse);
         check($sformatf("vec%0d num", i), int'(num), vecs[i].num);
      end

      // Key 5 held for a single sweep: rejected
      held[5] = 1'b1;
      tick(SWEEP);
      held[5] = 1'b0;
      tick(4 * SWEEP);
      check("short press count", int'(digit_count), 0);

      // Keys 5 and 6 held together: rejected
      held[5] = 1'b1;
      held[6] = 1'b1;
      tick(3 * SWEEP);
      held[5] = 1'b0;
      held[6] = 1'b0;
      tick(4 * SWEEP);
      check("multi press count", int'(digit_count), 0);
      check("multi press digits", int'(digits), 0);

      // Key 5 held properly
      press(5, 3);
      check("key5 digits", int'(digits), 'h0005);
      check("key5 count", int'(digit_count), 1);
      p0 = pulses;
      press(14, 3);
      check("enter5 num", int'(num), 5);
      check("enter5 pulses", pulses - p0, 1);

      // Reset while key 8 is held
      press(2, 3);
      press(6, 3);
      check("pre-reset digits", int'(digits), 'h0036);
      held[9] = 1'b1;
      tick(8);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      tick(1);
      check("mid reset digits", int'(digits), 0);
      check("mid reset count", int'(digit_count), 0);
      check("mid reset num", int'(num), 0);
      check("mid reset col", int'(col), 'b1110);
      tick(4 * SWEEP);
      check("held through reset count", int'(digit_count), 0);
      held[9] = 1'b0;
      tick(4 * SWEEP);
      check("after release count", int'(digit_count), 0);
      press(9, 3);
      check("repress 8 digits", int'(digits), 'h0008);
      check("repress 8 count", int'(digit_count), 1);
      press(11, 3);

      // Randomized key stream against a queue-based entry model
      q.delete();
      mnum = 0;
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 5) == 0) k = 14;
         else k = int'($urandom_range(0, 15));
         epulse = 0;
         d = digit_of(k);
         if (d >= 0) begin
            if (q.size() < 4) q.push_back(d);
         end else if (k == 13) begin
            if (q.size() > 0) void'(q.pop_back());
         end else if (k == 11) begin
            q.delete();
         end else if (k == 14) begin
            v = 0;
            foreach (q[j]) v = v * 10 + q[j];
            mnum = v;
            epulse = 1;
            q.delete();
         end
         exp_dig = 0;
         foreach (q[j]) exp_dig = exp_dig * 16 + q[j];

         p0 = pulses;
         press(k, 3);
         check($sformatf("rnd%0d key%0d digits", i, k), int'(digits), exp_dig);
         check($sformatf("rnd%0d key%0d count", i, k), int'(digit_count), q.size());
         check($sformatf("rnd%0d key%0d pulses", i, k), pulses - p0, epulse);
         check($sformatf("rnd%0d key%0d num", i, k), int'(num), mnum);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
